data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Data memory responder: a word-organised RAM behind a fixed-latency
// request/response handshake for the M stage of a pipelined core.
// Each accepted access stalls the pipeline for LATENCY+1 cycles and then
// produces a single-cycle rsp_valid pulse with formatted load data.
// Optional build macro: DMEM_MISALIGN_TRAP_EN adds the 'misaligned' output
// and turns misaligned half/word accesses into flagged no-ops; without it
// the low address bits are silently forced to natural alignment.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_f3,
    output logic [31:0] rsp_rdata,
    output logic        rsp_valid,
    output logic        stall
`ifdef DMEM_MISALIGN_TRAP_EN
    ,
    output logic        misaligned
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    logic          wr_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [2:0]    f3_q;

    logic [31:0] rdata_q, rdata_d;
`ifdef DMEM_MISALIGN_TRAP_EN
    logic        misal_q;
`endif

    logic [31:0] mem [DEPTH_WORDS];

    logic          accessNow;
    logic [AW-1:0] wordIdx;
    logic [1:0]    offset;
    logic          isHalf, isWord, isUnsup, isMisal, doWrite;
    logic [3:0]    byteEn;
    logic [31:0]   laneData, curWord, shifted, loadData;

    // Address bits above the memory size wrap around and are deliberately dropped.
    logic unusedAddrBits;
    assign unusedAddrBits = ^req_addr[31:AW+2];

    // State register and wait counter; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the request at accept so later input changes cannot disturb it.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            f3_q    <= 3'd0;
        end else if (state_q == IDLE && req_valid) begin
            wr_q    <= req_write;
            addr_q  <= req_addr[AW+1:0];
            wdata_q <= req_wdata;
            f3_q    <= req_f3;
        end
    end

    // Next-state logic: IDLE accepts, WAIT counts down, DONE returns to IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = WAIT;
                    cnt_d   = 4'(LATENCY - 1);
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Decode the latched access: lane enables, alignment handling and load formatting.
    always_comb begin
        accessNow = (state_q == WAIT) && (cnt_q == 4'd0);
        isHalf    = (f3_q[1:0] == 2'b01);
        isWord    = (f3_q == 3'b010);
        isUnsup   = (f3_q == 3'b011) || (f3_q[2:1] == 2'b11);
        offset    = addr_q[1:0];
`ifdef DMEM_MISALIGN_TRAP_EN
        isMisal   = (isHalf && addr_q[0]) || (isWord && (addr_q[1:0] != 2'b00));
`else
        isMisal   = 1'b0;
        if (isHalf) begin
            offset[0] = 1'b0;
        end
        if (isWord) begin
            offset = 2'b00;
        end
`endif
        wordIdx = addr_q[AW+1:2];
        curWord = mem[wordIdx];
        shifted = curWord >> {offset, 3'b000};

        case (f3_q)
            3'b000:  loadData = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  loadData = {{16{shifted[15]}}, shifted[15:0]};
            3'b010:  loadData = curWord;
            3'b100:  loadData = {24'd0, shifted[7:0]};
            3'b101:  loadData = {16'd0, shifted[15:0]};
            default: loadData = 32'd0;
        endcase

        case (f3_q)
            3'b000:  byteEn = 4'b0001 << offset;
            3'b001:  byteEn = 4'b0011 << offset;
            3'b010:  byteEn = 4'b1111;
            default: byteEn = 4'b0000;
        endcase

        case (f3_q)
            3'b000:  laneData = {4{wdata_q[7:0]}};
            3'b001:  laneData = {2{wdata_q[15:0]}};
            default: laneData = wdata_q;
        endcase

        doWrite = wr_q && !isMisal && (byteEn != 4'b0000);

        if (isUnsup || isMisal) begin
            rdata_d = 32'd0;
        end else if (!wr_q) begin
            rdata_d = loadData;
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Response data is registered at the access and held until the next load.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= 32'd0;
        end else if (accessNow) begin
            rdata_q <= rdata_d;
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    // Remember whether the completing access was misaligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            misal_q <= 1'b0;
        end else if (accessNow) begin
            misal_q <= isMisal;
        end
    end
`endif

    // Byte-lane memory write; storage is never cleared and a reset aborts the write.
    always_ff @(posedge clk) begin
        if (!reset && accessNow && doWrite) begin
            if (byteEn[0]) mem[wordIdx][7:0]   <= laneData[7:0];
            if (byteEn[1]) mem[wordIdx][15:8]  <= laneData[15:8];
            if (byteEn[2]) mem[wordIdx][23:16] <= laneData[23:16];
            if (byteEn[3]) mem[wordIdx][31:24] <= laneData[31:24];
        end
    end

    // Outputs: stall covers the accept cycle and all wait cycles, rsp_valid marks DONE.
    always_comb begin
        rsp_rdata = rdata_q;
        rsp_valid = (state_q == DONE);
        stall     = ((state_q == IDLE) && req_valid) || (state_q == WAIT);
`ifdef DMEM_MISALIGN_TRAP_EN
        misaligned = (state_q == DONE) && misal_q;
`endif
    end

endmodule
